// File: rtl/main_slave_port_loader.sv
// Host-side initiator for the accelerator `main` slave memory port: single-beat host accesses on channel 0,
// plus start/done handshake with a run cycle counter. Optional access timeout: define LOADER_TIMEOUT_EN.
module main_slave_port_loader #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned SIZE_W  = 7,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [SIZE_W-1:0]     cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  run_req,
    output logic                  run_busy,
    output logic                  run_done,
    output logic [CNT_W-1:0]      run_cycles,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_START,
        ST_RUN
    } state_t;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rsp_err;
`endif

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_pend_run;
    logic              r_oe0;
    logic              r_we0;
    logic [ADDR_W-1:0] r_addr0;
    logic [DATA_W-1:0] r_wdata0;
    logic [SIZE_W-1:0] r_size0;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_start;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  w_cycles_nxt;
    logic              w_unused_ok;

    // Run counter saturates rather than wrapping on very long runs
    always_comb begin
        w_cycles_nxt = r_cycles;
        if (r_cycles != {CNT_W{1'b1}}) begin
            w_cycles_nxt = r_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_pend_run  <= 1'b0;
            r_oe0       <= 1'b0;
            r_we0       <= 1'b0;
            r_addr0     <= '0;
            r_wdata0    <= '0;
            r_size0     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cycles    <= '0;
`ifdef LOADER_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A command wins over a simultaneous run request, which is kept pending
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= ST_ACCESS;
                        r_cmd_ready <= 1'b0;
                        r_pend_run  <= r_pend_run | run_req;
                        r_oe0       <= !cmd_write;
                        r_we0       <= cmd_write;
                        r_addr0     <= cmd_addr;
                        r_wdata0    <= cmd_write ? cmd_wdata : '0;
                        r_size0     <= cmd_size;
`ifdef LOADER_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end else if (run_req || r_pend_run) begin
                        r_state     <= ST_START;
                        r_cmd_ready <= 1'b0;
                        r_pend_run  <= 1'b0;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cycles    <= CNT_W'(1);
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_pend_run <= r_pend_run | run_req;
                    if (Sout_DataRdy[0]) begin
                        r_state     <= ST_RESP;
                        r_oe0       <= 1'b0;
                        r_we0       <= 1'b0;
                        r_addr0     <= '0;
                        r_wdata0    <= '0;
                        r_size0     <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_oe0 ? Sout_Rdata_ram[DATA_W-1:0] : '0;
`ifdef LOADER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_state     <= ST_RESP;
                        r_oe0       <= 1'b0;
                        r_we0       <= 1'b0;
                        r_addr0     <= '0;
                        r_wdata0    <= '0;
                        r_size0     <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    r_pend_run  <= r_pend_run | run_req;
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                ST_START: begin
                    // done_port is not looked at in the launch cycle
                    r_state  <= ST_RUN;
                    r_cycles <= w_cycles_nxt;
                end
                ST_RUN: begin
                    if (done_port) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cycles <= w_cycles_nxt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
`ifdef LOADER_TIMEOUT_EN
    assign rsp_err         = r_rsp_err;
`else
    assign rsp_err         = 1'b0;
`endif
    assign run_busy        = r_busy;
    assign run_done        = r_done;
    assign run_cycles      = r_cycles;
    assign start_port      = r_start;
    // Channel 1 is never used by the host loader
    assign S_oe_ram        = {1'b0, r_oe0};
    assign S_we_ram        = {1'b0, r_we0};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr0};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, r_wdata0};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, r_size0};

    assign w_unused_ok = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1], (TIMEOUT != 0)};

endmodule

// File: tb/tb_main_slave_port_loader.sv
// Bench for main_slave_port_loader: directed vector table, multi-cycle corner sequences and a
// randomized phase checked against a memory/run model kept in the bench.
module tb_main_slave_port_loader;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned SIZE_W  = 7;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic                  cmd_write = 1'b0;
    logic [ADDR_W-1:0]     cmd_addr = '0;
    logic [DATA_W-1:0]     cmd_wdata = '0;
    logic [SIZE_W-1:0]     cmd_size = '0;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  run_req = 1'b0;
    logic                  run_busy;
    logic                  run_done;
    logic [CNT_W-1:0]      run_cycles;
    logic                  start_port;
    logic                  done_port = 1'b0;
    logic [1:0]            S_oe_ram;
    logic [1:0]            S_we_ram;
    logic [2*ADDR_W-1:0]   S_addr_ram;
    logic [2*DATA_W-1:0]   S_Wdata_ram;
    logic [2*SIZE_W-1:0]   S_data_ram_size;
    logic [2*DATA_W-1:0]   Sout_Rdata_ram = '0;
    logic [1:0]            Sout_DataRdy = '0;

    always #5 clock = ~clock;

    main_slave_port_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_size       (cmd_size),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .run_req        (run_req),
        .run_busy       (run_busy),
        .run_done       (run_done),
        .run_cycles     (run_cycles),
        .start_port     (start_port),
        .done_port      (done_port),
        .S_oe_ram       (S_oe_ram),
        .S_we_ram       (S_we_ram),
        .S_addr_ram     (S_addr_ram),
        .S_Wdata_ram    (S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram (Sout_Rdata_ram),
        .Sout_DataRdy   (Sout_DataRdy)
    );

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic [6:0]  size;
        int          delay;
        logic [63:0] exp_rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] slv_mem [0:1023];
    logic [63:0] ref_mem [0:1023];
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oe"},     128'(S_oe_ram), 128'(0));
        chk({tag, "_we"},     128'(S_we_ram), 128'(0));
        chk({tag, "_addr"},   128'(S_addr_ram), 128'(0));
        chk({tag, "_wdata"},  128'(S_Wdata_ram), 128'(0));
        chk({tag, "_size"},   128'(S_data_ram_size), 128'(0));
        chk({tag, "_start"},  128'(start_port), 128'(0));
        chk({tag, "_busy"},   128'(run_busy), 128'(0));
        chk({tag, "_done"},   128'(run_done), 128'(0));
        chk({tag, "_cycles"}, 128'(run_cycles), 128'(0));
        chk({tag, "_rsp"},    128'(rsp_valid), 128'(0));
        chk({tag, "_rdata"},  128'(rsp_rdata), 128'(0));
        chk({tag, "_ready"},  128'(cmd_ready), 128'(0));
    endtask

    // Called at a negedge with the loader idle; returns at the negedge of the idle cycle after the response.
    // The slave answers on driven cycle delay+1, storing/returning data from its own memory.
    task automatic do_access(input logic wr, input logic [9:0] addr, input logic [63:0] wdata,
                             input logic [6:0] size, input int delay, input logic [63:0] exp_rdata,
                             input logic with_run);
        chk("pre_ready", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        run_req = with_run;
        @(negedge clock);
        cmd_valid = 1'b0; run_req = 1'b0;
        cmd_addr = 10'($urandom); cmd_wdata = {$urandom, $urandom}; cmd_size = 7'($urandom);
        for (int k = 0; k <= delay; k++) begin
            chk("drv_oe",   128'(S_oe_ram), 128'({1'b0, ~wr}));
            chk("drv_we",   128'(S_we_ram), 128'({1'b0, wr}));
            chk("drv_addr", 128'(S_addr_ram), 128'({10'b0, addr}));
            chk("drv_size", 128'(S_data_ram_size), 128'({7'b0, size}));
            if (wr) chk("drv_wdata", 128'(S_Wdata_ram), 128'({64'b0, wdata}));
            else    chk("drv_wdata_hi", 128'(S_Wdata_ram[127:64]), 128'(0));
            chk("acc_ready", 128'(cmd_ready), 128'(0));
            chk("acc_norsp", 128'(rsp_valid), 128'(0));
            Sout_DataRdy = {1'($urandom), 1'(k == delay)};
            if (k == delay) begin
                if (S_we_ram[0]) slv_mem[S_addr_ram[9:0]] = S_Wdata_ram[63:0];
                Sout_Rdata_ram = {$urandom, $urandom,
                                  (S_oe_ram[0] ? slv_mem[S_addr_ram[9:0]] : 64'(0))};
            end else begin
                Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clock);
        end
        Sout_DataRdy = '0;
        chk("rsp_valid", 128'(rsp_valid), 128'(1));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
        chk("rsp_err",   128'(rsp_err), 128'(0));
        chk("rsp_oe",    128'(S_oe_ram), 128'(0));
        chk("rsp_we",    128'(S_we_ram), 128'(0));
        chk("rsp_lines", 128'(S_addr_ram) | 128'(S_data_ram_size) | S_Wdata_ram, 128'(0));
        chk("rsp_ready", 128'(cmd_ready), 128'(0));
        @(negedge clock);
        chk("post_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("post_rsp_hold",  128'(rsp_rdata), 128'(exp_rdata));
        chk("post_ready",     128'(cmd_ready), 128'(1));
        chk("post_nostart",   128'(start_port), 128'(0));
    endtask

    task automatic run_launch();
        run_req = 1'b1;
        @(negedge clock);
        run_req = 1'b0;
    endtask

    // Called at the negedge of the launch cycle; done_port is raised d cycles after it.
    task automatic run_body(input int d, input logic done_in_start, input logic [31:0] exp_cycles);
        for (int k = 0; k <= d; k++) begin
            chk("run_start",  128'(start_port), 128'(k == 0));
            chk("run_busy",   128'(run_busy), 128'(1));
            chk("run_done0",  128'(run_done), 128'(0));
            chk("run_ready",  128'(cmd_ready), 128'(0));
            chk("run_count",  128'(run_cycles), 128'(k + 1));
            done_port = (k == d) || (k == 0 && done_in_start);
            @(negedge clock);
        end
        done_port = 1'b0;
        chk("run_done",      128'(run_done), 128'(1));
        chk("run_busy_end",  128'(run_busy), 128'(0));
        chk("run_cycles",    128'(run_cycles), 128'(exp_cycles));
        chk("run_end_ready", 128'(cmd_ready), 128'(1));
        @(negedge clock);
        chk("run_done_pulse", 128'(run_done), 128'(0));
        chk("run_cyc_frozen", 128'(run_cycles), 128'(exp_cycles));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sizes [4];
        logic        wr;
        logic        wrun;
        logic [9:0]  a;
        logic [63:0] wd;
        int          d;

        sizes = '{8, 16, 32, 64};
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        vecs[0] = '{1'b1, 10'h010, 64'hDEADBEEF,          7'd32, 0, 64'h0};
        vecs[1] = '{1'b0, 10'h010, 64'h0,                 7'd32, 1, 64'hDEADBEEF};
        vecs[2] = '{1'b1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 2, 64'h0};
        vecs[3] = '{1'b0, 10'h3FF, 64'h0,                 7'd64, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1'b1, 10'h000, 64'hA5,                7'd8,  0, 64'h0};
        vecs[5] = '{1'b0, 10'h000, 64'h0,                 7'd8,  2, 64'hA5};

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        chk("reset_err", 128'(rsp_err), 128'(0));
        reset = 1'b1;
        @(negedge clock);
        chk("idle_ready", 128'(cmd_ready), 128'(1));

        // Directed access vectors
        for (int i = 0; i < 6; i++) begin
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].delay,
                      vecs[i].exp_rdata, 1'b0);
            if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // Launch with done 10 cycles after start_port, then one with done in the launch cycle
        run_launch();
        run_body(10, 1'b0, 32'd11);
        run_launch();
        run_body(3, 1'b1, 32'd4);

        // Command and run request together: access first, launch two cycles after the response
        do_access(1'b0, 10'h010, 64'h0, 7'd32, 0, 64'hDEADBEEF, 1'b1);
        @(negedge clock);
        chk("pend_start", 128'(start_port), 128'(1));
        run_body(2, 1'b0, 32'd3);

        // Reset in the middle of an access
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010; cmd_size = 7'd32;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("rst_acc_pre_oe", 128'(S_oe_ram), 128'(1));
        #2 reset = 1'b0;
        #1 chk_all_zero("rst_acc");
        Sout_DataRdy = 2'b11;
        repeat (2) @(negedge clock);
        chk("rst_acc_norsp", 128'(rsp_valid), 128'(0));
        Sout_DataRdy = '0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_acc_rel_rsp",   128'(rsp_valid), 128'(0));
        chk("rst_acc_rel_ready", 128'(cmd_ready), 128'(1));

        // Reset in the launch cycle and later in the running phase
        run_launch();
        chk("rst_st_pre", 128'(start_port), 128'(1));
        #2 reset = 1'b0;
        #1 chk_all_zero("rst_start");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_launch();
        repeat (2) @(negedge clock);
        chk("rst_run_pre", 128'(run_busy), 128'(1));
        #2 reset = 1'b0;
        #1 chk_all_zero("rst_run");
        done_port = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rst_run_nodone", 128'(run_done), 128'(0));
            chk("rst_run_nobusy", 128'(run_busy), 128'(0));
        end
        done_port = 1'b0;
        @(negedge clock);

        // Slave that never answers
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h007; cmd_size = 7'd16;
        @(negedge clock);
        cmd_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("to_oe",    128'(S_oe_ram), 128'(1));
            chk("to_norsp", 128'(rsp_valid), 128'(0));
            @(negedge clock);
        end
        chk("to_rsp",   128'(rsp_valid), 128'(1));
        chk("to_err",   128'(rsp_err), 128'(1));
        chk("to_rdata", 128'(rsp_rdata), 128'(0));
        chk("to_oe_off", 128'(S_oe_ram), 128'(0));
        @(negedge clock);
        chk("to_ready", 128'(cmd_ready), 128'(1));
`else
        for (int k = 0; k < 20; k++) begin
            chk("wait_oe",    128'(S_oe_ram), 128'(1));
            chk("wait_norsp", 128'(rsp_valid), 128'(0));
            @(negedge clock);
        end
        Sout_DataRdy = 2'b01;
        Sout_Rdata_ram = {64'hFFFF_0000_FFFF_0000, 64'h1234};
        @(negedge clock);
        Sout_DataRdy = '0;
        chk("wait_rsp",   128'(rsp_valid), 128'(1));
        chk("wait_rdata", 128'(rsp_rdata), 128'(64'h1234));
        chk("wait_err",   128'(rsp_err), 128'(0));
        @(negedge clock);
`endif

        // Randomized traffic against the memory and run model
        for (int n = 0; n < 80; n++) begin
            d = int'($urandom_range(0, 2));
            a = 10'($urandom_range(0, 31) * 8);
            if ($urandom_range(0, 9) == 0) begin
                d = int'($urandom_range(1, 6));
                run_launch();
                run_body(d, 1'($urandom), 32'(d + 1));
            end else begin
                wr = ($urandom_range(0, 1) == 1);
                wd = {$urandom, $urandom};
                wrun = ($urandom_range(0, 7) == 0);
                if (wr) begin
                    do_access(1'b1, a, wd, 7'(sizes[$urandom_range(0, 3)]), d, 64'h0, wrun);
                    ref_mem[a] = wd;
                end else begin
                    do_access(1'b0, a, wd, 7'(sizes[$urandom_range(0, 3)]), d, ref_mem[a], wrun);
                end
                if (wrun) begin
                    @(negedge clock);
                    chk("rnd_pend_start", 128'(start_port), 128'(1));
                    d = int'($urandom_range(1, 5));
                    run_body(d, 1'b0, 32'(d + 1));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
